// File: rtl/cic_pkg.sv
// Shared constants and helpers for the CIC decimator.
package cic_pkg;

  localparam int ORDER_DEF      = 3;
  localparam int DECIM_LOG2_DEF = 6;
  localparam int OUT_BITS_DEF   = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int acc_width(input int order,
                                   input int dlog2);
    return order * dlog2 + 1;
  endfunction

  function automatic int max_out_of(input int ob);
    return (1 << (ob - 1)) - 1;
  endfunction

  function automatic int half_of(input int aw);
    return 1 << (aw - 2);
  endfunction

  localparam int ACC_W =
    acc_width(ORDER_DEF, DECIM_LOG2_DEF);
  localparam int MAX_OUT = max_out_of(OUT_BITS_DEF);
  localparam int HALF    = half_of(ACC_W);

endpackage

// File: rtl/cic_comb_stage.sv
// One M=1 comb section; advances only on its enable,
// and forwards the enable one cycle later.
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int ACC_W = cic_pkg::ACC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [ACC_W-1:0] x,
  output logic [ACC_W-1:0] y,
  output logic             en_out
);

  logic [ACC_W-1:0] x_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      y      <= '0;
      x_prev <= '0;
      en_out <= 1'b0;
    end else begin
      en_out <= en;
      if (en) begin
        y      <= x - x_prev;
        x_prev <= x;
      end
    end
  end

endmodule

// File: rtl/cic_decimator.sv
// sinc^N decimator: 1-bit bitstream in, signed PCM out
// at clk/R when din_en is held high.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int ORDER      = 3,
  parameter int DECIM_LOG2 = 6,
  parameter int OUT_BITS   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                din_en,
  input  logic                din,
  output logic [OUT_BITS-1:0] dout,
  output logic                dout_valid,
  output logic                dout_sat
);

  localparam int AW = acc_width(ORDER, DECIM_LOG2);
  localparam int SHIFT = AW - 1 - OUT_BITS;
  localparam logic signed [AW:0] HALF_S =
    (AW+1)'(half_of(AW));
  localparam logic signed [AW:0] MAX_S =
    (AW+1)'(max_out_of(OUT_BITS));

  logic [AW-1:0]         integ [ORDER];
  logic [AW-1:0]         din_ext;
  logic [DECIM_LOG2-1:0] cnt;
  logic                  stb;
  logic                  stb_q;
  logic                  tap_v;
  logic [AW-1:0]         tap;
  logic [AW-1:0]         cx [ORDER+1];
  logic [ORDER:0]        ce;
  logic signed [AW:0]    s;
  logic signed [AW:0]    q;
  logic                  sat;

  assign din_ext = {{(AW-1){1'b0}}, din};
  assign stb     = din_en && (cnt == '1);

  for (genvar k = 0; k < ORDER; k++) begin : g_int
    if (k == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (reset)       integ[k] <= '0;
        else if (din_en) integ[k] <= integ[k] + din_ext;
      end
    end else begin : g_rest
      always_ff @(posedge clk) begin
        if (reset)       integ[k] <= '0;
        else if (din_en) integ[k] <= integ[k] + integ[k-1];
      end
    end
  end

  // The tap captures the last integrator one edge after
  // the strobe, i.e. its value including the R-th bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      stb_q <= 1'b0;
      tap_v <= 1'b0;
      tap   <= '0;
    end else begin
      if (din_en) cnt <= cnt + 1'b1;
      stb_q <= stb;
      tap_v <= stb_q;
      if (stb_q) tap <= integ[ORDER-1];
    end
  end

  assign cx[0] = tap;
  assign ce[0] = tap_v;

  for (genvar k = 0; k < ORDER; k++) begin : g_comb
    cic_comb_stage #(.ACC_W(AW)) u_comb (
      .clk    (clk),
      .reset  (reset),
      .en     (ce[k]),
      .x      (cx[k]),
      .y      (cx[k+1]),
      .en_out (ce[k+1])
    );
  end

  always_comb begin
    s   = $signed({1'b0, cx[ORDER]}) - HALF_S;
    q   = s >>> SHIFT;
    sat = (q > MAX_S);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_sat   <= 1'b0;
    end else begin
      dout_valid <= ce[ORDER];
      if (ce[ORDER]) begin
        dout     <= sat ? MAX_S[OUT_BITS-1:0]
                        : q[OUT_BITS-1:0];
        dout_sat <= sat;
      end
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator at default parameters.
module tb_cic_decimator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        din_en = 1'b0;
  logic        din = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_sat;

  int cyc = 0;
  int nvec = 0;
  int nfail = 0;

  typedef struct {
    string      name;
    logic [3:0] pat;
    int         plen;
    logic [15:0] exp_dout;
    logic       exp_sat;
  } vec_t;

  vec_t vecs [4];

  cic_decimator dut (
    .clk        (clk),
    .reset      (reset),
    .din_en     (din_en),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_sat   (dout_sat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name,
                       input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    din_en = 1'b0;
    din    = 1'b0;
    tick();
    reset  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int b, words, last;
    do_reset();
    din_en = 1'b1;
    b      = 0;
    din    = v.pat[0];
    words  = 0;
    last   = -1;
    for (int t = 0; t < 8 * 64 + 200 && words < 8; t++) begin
      tick();
      b++;
      din = v.pat[b % v.plen];
      if (dout_valid) begin
        words++;
        if (words > 3) begin
          check({v.name, "_dout"}, dout, v.exp_dout);
          check({v.name, "_sat"}, dout_sat, v.exp_sat);
          check({v.name, "_period"}, cyc - last, 64);
        end
        last = cyc;
      end
    end
    check({v.name, "_words"}, words, 8);
  endtask

  initial begin
    vecs[0] = '{"ones",  4'b1111, 4, 16'h7FFF, 1'b1};
    vecs[1] = '{"zeros", 4'b0000, 4, 16'h8000, 1'b0};
    vecs[2] = '{"alt",   4'b0101, 2, 16'h0000, 1'b0};
    vecs[3] = '{"quart", 4'b0001, 4, 16'hC000, 1'b0};

    do_reset();
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_sat", dout_sat, 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    begin : latency
      int t0;
      bit seen;
      do_reset();
      din_en = 1'b1;
      din    = 1'b1;
      t0     = cyc + 1;
      seen   = 1'b0;
      for (int t = 0; t < 200 && !seen; t++) begin
        tick();
        if (dout_valid) seen = 1'b1;
      end
      check("lat_seen", seen, 1);
      check("lat_cycles", cyc - t0, 68);
    end

    begin : toggle
      int b, words, last;
      bit acc;
      do_reset();
      din_en = 1'b1;
      b      = 0;
      din    = 1'b1;
      words  = 0;
      last   = -1;
      for (int t = 0; t < 7 * 128 + 200 && words < 6; t++) begin
        acc = din_en;
        tick();
        if (acc) b++;
        din_en = ~din_en;
        din    = ((b % 4) == 0);
        if (dout_valid) begin
          words++;
          if (words > 3) begin
            check("tog_dout", dout, 16'hC000);
            check("tog_period", cyc - last, 128);
          end
          last = cyc;
        end
      end
      check("tog_words", words, 6);
    end

    begin : midreset
      int words, t0;
      bit seen;
      do_reset();
      din_en = 1'b1;
      din    = 1'b1;
      words  = 0;
      for (int t = 0; t < 6 * 64 && words < 4; t++) begin
        tick();
        if (dout_valid) words++;
      end
      check("mr_pre_sat", dout_sat, 1);
      for (int t = 0; t < 25; t++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mr_dout", dout, 0);
      check("mr_valid", dout_valid, 0);
      check("mr_sat", dout_sat, 0);
      t0   = cyc + 1;
      seen = 1'b0;
      for (int t = 0; t < 200 && !seen; t++) begin
        tick();
        if (dout_valid) seen = 1'b1;
      end
      check("mr_seen", seen, 1);
      check("mr_lat", cyc - t0, 68);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end

endmodule
